// File: rtl/sramlike_pkg.sv
// Shared types and helpers for the sram-like responder: size encodings,
// the response queue entry, and byte-lane write-enable decoding.
package sramlike_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic        is_read;
    logic [3:0]  wait_cnt;
    logic [31:0] data;
    logic        data_valid;
  } resp_entry_t;

  // Reserved size (3) is treated like a word access.
  function automatic logic [3:0] wen_from_size(input logic [1:0] size,
                                               input logic [1:0] offset);
    case (size)
      SIZE_BYTE: return 4'b0001 << offset;
      SIZE_HALF: return offset[1] ? 4'b1100 : 4'b0011;
      default:   return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/sramlike_resp_fifo.sv
// In-order response queue: one entry per accepted request, each with its own
// delay counter; read entries pick up SRAM data the cycle after they are pushed.
module sramlike_resp_fifo
  import sramlike_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int DATA_DELAY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        push_is_read,
  input  logic        pop,
  input  logic [31:0] cap_data,
  output logic        full,
  output logic        head_ready,
  output logic [31:0] head_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [3:0]       DELAY_INIT = 4'(DATA_DELAY);

  resp_entry_t      entries [DEPTH];
  resp_entry_t      head_entry;
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [PTR_W-1:0] cap_idx;
  logic [CNT_W-1:0] count;
  logic             cap_pending;
  logic             head_cap;

  // The head may retire on the very cycle its read data arrives (bypass path).
  always_comb begin
    head_entry = entries[head_ptr];
    head_cap   = cap_pending && head_entry.is_read && (cap_idx == head_ptr);
    head_ready = (count != '0) && (head_entry.wait_cnt == 4'd0) &&
                 (head_entry.data_valid || head_cap);
    head_data  = head_cap ? cap_data : head_entry.data;
    full       = (count == FULL_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr    <= '0;
      tail_ptr    <= '0;
      cap_idx     <= '0;
      count       <= '0;
      cap_pending <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entries[i].wait_cnt != 4'd0) begin
          entries[i].wait_cnt <= entries[i].wait_cnt - 4'd1;
        end
      end

      if (cap_pending) begin
        entries[cap_idx].data       <= cap_data;
        entries[cap_idx].data_valid <= 1'b1;
      end

      cap_pending <= push && push_is_read;

      // Push last so a fresh entry is never touched by the updates above.
      if (push) begin
        entries[tail_ptr] <= '{is_read:    push_is_read,
                               wait_cnt:   DELAY_INIT,
                               data:       32'd0,
                               data_valid: ~push_is_read};
        cap_idx  <= tail_ptr;
        tail_ptr <= (tail_ptr == LAST_IDX) ? '0 : tail_ptr + 1'b1;
      end

      if (pop) begin
        head_ptr <= (head_ptr == LAST_IDX) ? '0 : head_ptr + 1'b1;
      end

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sramlike_sram_responder.sv
// Responder end of the sram-like handshake, bridging to a 1-cycle-latency
// synchronous SRAM and returning responses strictly in acceptance order.
module sramlike_sram_responder
  import sramlike_pkg::*;
#(
  parameter int DATA_DELAY  = 0,
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        addr_ok,
  output logic        data_ok,
  input  logic        stall_inject,
  output logic        ram_en,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  logic        q_full;
  logic        q_ready;
  logic [31:0] q_data;

  // Fullness uses the pre-retire count, so a retire never frees a slot early.
  always_comb begin
    addr_ok   = req & ~stall_inject & ~q_full & ~rst;
    ram_en    = addr_ok;
    ram_wen   = (wr & addr_ok) ? wen_from_size(size, addr[1:0]) : 4'b0000;
    ram_addr  = addr;
    ram_wdata = wdata;
    data_ok   = q_ready & ~rst;
    rdata     = data_ok ? q_data : 32'd0;
  end

  sramlike_resp_fifo #(
    .DEPTH      (OUTSTANDING),
    .DATA_DELAY (DATA_DELAY)
  ) u_resp_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (addr_ok),
    .push_is_read (~wr),
    .pop          (data_ok),
    .cap_data     (ram_rdata),
    .full         (q_full),
    .head_ready   (q_ready),
    .head_data    (q_data)
  );

endmodule

// File: doc/sramlike_sram_responder.md
Name: sramlike_sram_responder

Overview:
- Slave (responder) end of the sram-like handshake (req/wr/size/addr/wdata, addr_ok/data_ok/rdata).
- Accepts requests from a CPU-side sram-like master and drives a synchronous SRAM port with 1-cycle read latency.
- Returns responses strictly in order, with a configurable extra data delay and a bounded number of outstanding requests.
- Used as the memory-side model and bridge for instruction and data fetch paths in SoC and simulation builds.

Parameters:
- DATA_DELAY, 0, extra cycles inserted before data_ok beyond the minimum latency (0..15).
- OUTSTANDING, 2, max accepted-but-unanswered requests (power of 2, 1..8).

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  synchronous active-high reset.
- req  input  1  master request valid.
- wr  input  1  1 = write, 0 = read.
- size  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- addr  input  32  byte address.
- wdata  input  32  write data, lane-aligned by the master.
- rdata  output  32  read data, valid when data_ok is high.
- addr_ok  output  1  request accepted this cycle.
- data_ok  output  1  response for the oldest accepted request.
- stall_inject  input  1  verification hook; forces addr_ok low.
- ram_en  output  1  SRAM access enable.
- ram_wen  output  4  SRAM byte write enables.
- ram_addr  output  32  SRAM byte address, equal to addr.
- ram_wdata  output  32  equal to wdata.
- ram_rdata  input  32  SRAM data, valid the cycle after a read with ram_en high.

Behaviour:
- Reset: addr_ok=0, data_ok=0, rdata=0, ram_en=0, ram_wen=0. Response queue emptied, all counters cleared.
- Acceptance (combinational):
  - addr_ok = req & ~stall_inject & (count < OUTSTANDING) & ~rst.
  - count is the value before this cycle's retire. A full queue blocks acceptance even if a retire happens in the same cycle.
- SRAM issue: same cycle as acceptance.
  - ram_en = addr_ok; ram_wen is 0 unless wr & addr_ok.
  - byte: ram_wen = 1 << addr[1:0].
  - half: addr[1] ? 4'b1100 : 4'b0011 (addr[0] ignored).
  - word or reserved size: 4'b1111. Misalignment is not checked.
- Queue entry: pushed on acceptance with fields {is_read, wait_cnt = DATA_DELAY, data, data_valid}.
  - A read entry captures ram_rdata in the cycle after acceptance and sets data_valid.
  - A write entry sets data_valid immediately and carries data 0.
- wait_cnt: every entry with wait_cnt > 0 decrements each cycle, including the push cycle's successor.
- Retire:
  - data_ok = head valid & (head wait_cnt == 0) & (head data_valid | head capture this cycle).
  - rdata = ram_rdata when the head captures this cycle (bypass), else the stored head data; 0 when data_ok is low.
  - data_ok pops the head. At most one retire per cycle.
- Latency: a request accepted in cycle T gets data_ok no earlier than T+1+DATA_DELAY. It also cannot come before all older requests have retired.
- data_ok is never asserted in the acceptance cycle of the same request.
- Ordering: responses are strictly FIFO regardless of mix of reads and writes.
- Simultaneous push and pop: count is unchanged and both take effect.
- Wrap-around: head and tail pointers wrap at OUTSTANDING.
- Reset mid-operation: the queue is flushed and no stale data_ok appears after reset. SRAM writes already issued are not undone.
- The master must hold req/addr/wr/size/wdata stable until addr_ok. The block does not check this.

Decomposition:
- Shared package sramlike_pkg:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD constants.
  - the response entry struct.
  - a wen-from-size/offset function.
- One natural sub-module: sramlike_resp_fifo, the parameterised in-order response queue with per-entry wait counters and a read-capture port.

Test Plan:
- Single read:
  - Setup: DATA_DELAY=0; SRAM word 0x100 = 0xDEADBEEF; req=1, wr=0, addr=0x100 at T.
  - Required: addr_ok at T, ram_en at T with ram_wen=0; data_ok at T+1 with rdata=0xDEADBEEF.
- Byte and half writes:
  - size=0, addr=0x203 -> ram_wen=4'b1000.
  - size=1, addr=0x202 -> ram_wen=4'b1100.
  - Each gets data_ok exactly one cycle after its addr_ok; a readback of 0x200 returns the merged word.
- Back-to-back reads:
  - Setup: OUTSTANDING=2, DATA_DELAY=2; req held with addrs 0x0, 0x4, 0x8.
  - Required: addr_ok for the first two only; the third is blocked until the first data_ok.
  - Required: data_ok at T+3 and T+4 in order with the correct words.
- Stall injection: stall_inject=1 for 5 cycles while req=1 -> addr_ok=0 and ram_en=0 throughout; acceptance occurs in the first cycle with stall_inject=0.
- Full plus simultaneous retire: queue full and head retiring in the same cycle as a new req -> addr_ok=0 that cycle, 1 the next cycle.
- Reset mid-flight: assert rst with 2 requests outstanding -> data_ok=0 from the next cycle onward and count=0; a fresh read then completes normally.
